// File: rtl/ras_stack.sv
// ras_stack: return-address stack for the JAL/JR link path.
//   clk, reset_n        : clock (rising edge), asynchronous active-low reset
//   push, pop           : JAL / JR retiring this cycle
//   superbit            : current supervisor/user mode bit
//   PCp4, radata        : link address source, JR source register data
//   top, valid, full    : predicted return address and occupancy flags
//   count               : number of valid entries, 0..DEPTH
//   overflow, underflow : one-cycle pulses for wrap-on-push and pop-on-empty
//   mispredict          : one-cycle pulse when the popped prediction missed
module ras_stack #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          superbit,
    input  logic [31:0]   PCp4,
    input  logic [31:0]   radata,
    output logic [31:0]   top,
    output logic          valid,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    output logic          mispredict
);
    logic [31:0]   entry [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW-1:0] tptr;
    logic [31:0]   pv;
    logic [31:0]   tgt;
    logic          miss;
    logic          unused;

    // PCp4[31] is replaced by the mode bit in the stored link address.
    assign unused = PCp4[31];
    assign tptr   = ptr - AW'(1);
    assign valid  = count != '0;
    assign full   = count == (AW+1)'(DEPTH);
    assign top    = valid ? entry[tptr] : '0;
    assign pv     = {superbit, PCp4[30:0]};
    // Same rule as the jump unit's JUMP_RA: supervisor may jump into user space.
    assign tgt    = (superbit && !radata[31]) ? radata : {superbit, radata[30:0]};
    assign miss   = top != tgt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
            ptr        <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            mispredict <= 1'b0;
            if (pop && !valid) begin
                underflow  <= 1'b1;
                mispredict <= 1'b1;
            end
            // A push on an empty stack behaves as a plain push even with pop.
            if (push && (!pop || !valid)) begin
                entry[ptr] <= pv;
                ptr        <= ptr + AW'(1);
                if (full) overflow <= 1'b1;
                else count <= count + 1'b1;
            end else if (pop && valid) begin
                mispredict <= miss;
                if (push) entry[tptr] <= pv;
                else begin
                    ptr   <= tptr;
                    count <= count - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ras_stack.sv
// tb_ras_stack: directed self-checking bench for ras_stack (DEPTH=8).
module tb_ras_stack;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        superbit = 1'b0;
    logic [31:0] PCp4 = '0;
    logic [31:0] radata = '0;
    logic [31:0] top;
    logic        valid;
    logic        full;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;
    logic        mispredict;
    int          checks = 0;
    int          fails = 0;

    ras_stack #(.DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .superbit(superbit),
        .PCp4(PCp4), .radata(radata), .top(top), .valid(valid), .full(full),
        .count(count), .overflow(overflow), .underflow(underflow), .mispredict(mispredict)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, then sample 1ns after the rising edge.
    task automatic step(input logic pu, input logic po, input logic sb,
                        input logic [31:0] pc, input logic [31:0] ra);
        push = pu; pop = po; superbit = sb; PCp4 = pc; radata = ra;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step(0, 0, 0, 0, 0);
        checks++; if (top !== 32'h0) begin fails++; $display("FAIL reset_top got %h exp 0", top); end
        checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if ({overflow, underflow, mispredict} !== 3'b000) begin fails++; $display("FAIL reset_pulses got %b exp 000", {overflow, underflow, mispredict}); end
    endtask

    task automatic test_push_pop;
        step(1, 0, 0, 32'h0040_0010, 0);
        step(1, 0, 0, 32'h0040_0020, 0);
        checks++; if (top !== 32'h0040_0020) begin fails++; $display("FAIL pp_top got %h exp 00400020", top); end
        checks++; if (count !== 4'd2) begin fails++; $display("FAIL pp_count got %0d exp 2", count); end
        step(0, 1, 0, 0, 32'h0040_0020);
        checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL pp_mispredict got %b exp 0", mispredict); end
        checks++; if (top !== 32'h0040_0010) begin fails++; $display("FAIL pp_top_after_pop got %h exp 00400010", top); end
        checks++; if (count !== 4'd1) begin fails++; $display("FAIL pp_count_after_pop got %0d exp 1", count); end
        step(0, 1, 0, 0, 32'h0040_0010);
        checks++; if ({count, mispredict} !== {4'd0, 1'b0}) begin fails++; $display("FAIL pp_drain got count %0d misp %b exp 0 0", count, mispredict); end
    endtask

    task automatic test_superbit;
        step(1, 0, 1, 32'h0000_0044, 0);
        checks++; if (top !== 32'h8000_0044) begin fails++; $display("FAIL sb_top got %h exp 80000044", top); end
        step(0, 1, 1, 0, 32'h0000_0044);
        checks++; if (mispredict !== 1'b1) begin fails++; $display("FAIL sb_mispredict got %b exp 1", mispredict); end
        checks++; if (count !== 4'd0) begin fails++; $display("FAIL sb_count got %0d exp 0", count); end
        step(0, 0, 0, 0, 0);
        checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL sb_pulse_clear got %b exp 0", mispredict); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 0, 32'h100 + 32'(4 * i), 0);
            checks++; if (overflow !== (i == 8)) begin fails++; $display("FAIL ovf_push%0d got %b exp %b", i, overflow, i == 8); end
        end
        checks++; if ({count, full} !== {4'd8, 1'b1}) begin fails++; $display("FAIL ovf_full got count %0d full %b exp 8 1", count, full); end
        checks++; if (top !== 32'h120) begin fails++; $display("FAIL ovf_top got %h exp 120", top); end
        step(0, 0, 0, 0, 0);
        checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_pulse_clear got %b exp 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (top !== 32'h120 - 32'(4 * i)) begin fails++; $display("FAIL ovf_pop%0d_top got %h exp %h", i, top, 32'h120 - 32'(4 * i)); end
            step(0, 1, 0, 0, 32'h120 - 32'(4 * i));
            checks++; if ({mispredict, underflow} !== 2'b00) begin fails++; $display("FAIL ovf_pop%0d_pulses got %b exp 00", i, {mispredict, underflow}); end
        end
        checks++; if ({count, valid} !== {4'd0, 1'b0}) begin fails++; $display("FAIL ovf_empty got count %0d valid %b exp 0 0", count, valid); end
    endtask

    task automatic test_underflow;
        step(0, 1, 0, 0, 32'h1234);
        checks++; if ({underflow, mispredict} !== 2'b11) begin fails++; $display("FAIL udf_pulses got %b exp 11", {underflow, mispredict}); end
        checks++; if (count !== 4'd0) begin fails++; $display("FAIL udf_count got %0d exp 0", count); end
        step(0, 0, 0, 0, 0);
        checks++; if ({underflow, mispredict} !== 2'b00) begin fails++; $display("FAIL udf_clear got %b exp 00", {underflow, mispredict}); end
        step(1, 1, 0, 32'h200, 32'h200);
        checks++; if ({count, top} !== {4'd1, 32'h200}) begin fails++; $display("FAIL udf_pushpop got count %0d top %h exp 1 200", count, top); end
        checks++; if ({underflow, mispredict, overflow} !== 3'b110) begin fails++; $display("FAIL udf_pushpop_pulses got %b exp 110", {underflow, mispredict, overflow}); end
    endtask

    task automatic test_back_to_back;
        step(1, 0, 0, 32'h210, 0);
        step(1, 0, 0, 32'h220, 0);
        checks++; if ({count, top} !== {4'd3, 32'h220}) begin fails++; $display("FAIL b2b_setup got count %0d top %h exp 3 220", count, top); end
        step(1, 1, 0, 32'h300, 32'h220);
        checks++; if ({count, top} !== {4'd3, 32'h300}) begin fails++; $display("FAIL b2b_replace got count %0d top %h exp 3 300", count, top); end
        checks++; if (mispredict !== 1'b0) begin fails++; $display("FAIL b2b_mispredict got %b exp 0", mispredict); end
        step(1, 1, 0, 32'h310, 32'h999);
        checks++; if ({top, mispredict} !== {32'h310, 1'b1}) begin fails++; $display("FAIL b2b_miss got top %h misp %b exp 310 1", top, mispredict); end
        step(0, 1, 0, 0, 32'h310);
        checks++; if ({count, top} !== {4'd2, 32'h210}) begin fails++; $display("FAIL b2b_pop got count %0d top %h exp 2 210", count, top); end
        step(0, 1, 1, 0, 32'h8000_0210);
        checks++; if (mispredict !== 1'b1) begin fails++; $display("FAIL b2b_user_tgt got %b exp 1", mispredict); end
        step(0, 1, 0, 0, 32'hdead_0200);
        checks++; if (mispredict !== 1'b1) begin fails++; $display("FAIL b2b_miss2 got %b exp 1", mispredict); end
        checks++; if (count !== 4'd0) begin fails++; $display("FAIL b2b_drained got %0d exp 0", count); end
        step(1, 0, 0, 32'h400, 0);
        step(0, 1, 0, 0, 32'h777);
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({top, valid, full, count} !== {32'h0, 1'b0, 1'b0, 4'd0}) begin fails++; $display("FAIL async_reset_state got top %h valid %b full %b count %0d exp 0", top, valid, full, count); end
        checks++; if ({overflow, underflow, mispredict} !== 3'b000) begin fails++; $display("FAIL async_reset_pulses got %b exp 000", {overflow, underflow, mispredict}); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(0, 0, 0, 0, 0);
        checks++; if ({count, top} !== {4'd0, 32'h0}) begin fails++; $display("FAIL post_reset got count %0d top %h exp 0 0", count, top); end
    endtask

    initial begin
        test_reset;
        test_push_pop;
        test_superbit;
        test_overflow;
        test_underflow;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Return-address stack for the single-cycle MIPS core; the producer side of the JAL/JR link path.
- On JAL it pushes the link address (PC+4 tagged with the supervisor bit). On JR it pops, exposing the predicted return target.
- When the JR retires, it checks the prediction against the actual JR target, which is formed by the same rule the jump unit uses for JUMP_RA.
- Sits beside the PC/jump logic in the datapath; driven by the controller's push/pop strobes.

Parameters:
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- push  input  1  JAL retiring this cycle.
- pop  input  1  JR retiring this cycle.
- superbit  input  1  current supervisor/user mode bit (PC MSB).
- PCp4  input  32  current instruction address + 4.
- radata  input  32  register-file read data 1 (JR source).
- top  output  32  predicted return address (current top entry).
- valid  output  1  stack non-empty.
- full  output  1  count == DEPTH.
- count  output  AW+1  number of valid entries, 0..DEPTH.
- overflow  output  1  one-cycle pulse: oldest entry was overwritten.
- underflow  output  1  one-cycle pulse: pop on empty stack.
- mispredict  output  1  one-cycle pulse: popped prediction did not match the JR target.

Behaviour:
- Reset (reset_n low, asynchronous):
  - ptr=0, count=0, all entries=0.
  - top=0, valid=0, full=0; overflow, underflow and mispredict all 0.
  - Reset mid-operation discards all contents immediately.
- Storage:
  - Circular array entry[0..DEPTH-1]; ptr is the next write slot.
  - Top entry is entry[ptr-1] (mod DEPTH).
- Pushed value: {superbit, PCp4[30:0]}.
- top, valid, full, count:
  - Combinational from registered state.
  - top = entry[ptr-1] when count>0, else 0.
  - A push becomes visible on top on the cycle after the push edge.
- JR target (combinational, identical to the jump unit's JUMP_RA rule):
  - tgt = radata when superbit==1 and radata[31]==0.
  - Otherwise tgt = {superbit, radata[30:0]}.
- Push only:
  - Write entry[ptr]; ptr<=ptr+1 mod DEPTH.
  - If count<DEPTH: count<=count+1, overflow<=0.
  - If full: count stays DEPTH, the oldest entry is overwritten (wrap), overflow<=1 for one cycle.
- Pop only:
  - count>0: ptr<=ptr-1, count<=count-1, underflow<=0, mispredict<=(top!=tgt).
  - count==0: state unchanged, underflow<=1, mispredict<=1.
- Push and pop together:
  - count>0: overwrite entry[ptr-1] with the new value; ptr and count unchanged; mispredict<=(top!=tgt) uses the pre-write top.
  - count==0: behaves as push-only (count becomes 1), plus underflow<=1 and mispredict<=1.
- Neither push nor pop: state holds; overflow, underflow and mispredict return to 0.
- All pulse outputs are registered and high for exactly one cycle after the triggering edge. They are never sticky.
- Pointer arithmetic is modulo DEPTH; count saturates at DEPTH and never wraps below 0.

Test Plan:
1. Reset, then idle -> top=0, valid=0, count=0, full=0; all pulses 0.
2. superbit=0; push with PCp4=0x00400010, then PCp4=0x00400020 -> next cycle top=0x00400020, count=2. Pop with radata=0x00400020 -> mispredict=0, top=0x00400010, count=1.
3. superbit=1; push PCp4=0x00000044. Pop with radata=0x00000044 (bit31=0, so tgt=radata) -> top was 0x80000044, mispredict=1 for one cycle, count=0.
4. DEPTH=8; 9 pushes with PCp4=0x100,0x104,...,0x120, superbit=0 -> overflow pulse after 9th push only, count=8, full=1, top=0x120. Then 8 pops -> last pop shows top=0x104 (0x100 lost); count=0, valid=0.
5. Pop on empty -> underflow=1 and mispredict=1 for one cycle, count stays 0. Simultaneous push(0x200)+pop on empty -> count=1, top=0x200, underflow=1.
6. count=3, simultaneous push(0x300)+pop with radata equal to old top -> count stays 3, top=0x300, mispredict=0. Assert reset_n low mid-sequence -> all outputs 0 before the next clock edge.
